// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: repeated addition over an accumulate datapath
// (accumulator register, feedback adder, zero/multiplicand mux) with a start/done handshake.
// Optional build macro MULT_SATURATE_EN: clamp the accumulator to all ones after a carry-out.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [CNT_WIDTH-1:0] multiplicador,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     resultado,
    output logic                 overflow,
    output logic                 sel_mux,
    output logic                 enable
);

    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_WIDTH-1:0] mplier_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     mux_out;
    logic [WIDTH-1:0]     fb_out;
    logic [SUM_W-1:0]     sum_full;
    logic [WIDTH-1:0]     sum;
    logic                 cout;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, datapath strobes and the next values of the registered handshake flags
    always_comb begin
        state_d = state_q;
        sel_mux = 1'b0;
        enable  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                enable  = 1'b1;
                state_d = (mplier_q == '0) ? S_DONE : S_ADD;
            end
            S_ADD: begin
                sel_mux = 1'b1;
                enable  = 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CLEAR) || (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // Operand capture on acceptance; iteration counter loaded in CLEAR, counted down in ADD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q  <= multiplicando;
                        mplier_q <= multiplicador;
                    end
                end
                S_CLEAR: cnt_q <= mplier_q;
                S_ADD:   cnt_q <= cnt_q - CNT_WIDTH'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Zero/multiplicand mux; the feedback path is gated too so CLEAR loads a true zero
    assign mux_out = sel_mux ? mcand_q : '0;
    assign fb_out  = sel_mux ? acc_q : '0;

    // Feedback adder with carry-out
    assign sum_full = SUM_W'(fb_out) + SUM_W'(mux_out);
    assign sum      = sum_full[WIDTH-1:0];
    assign cout     = sum_full[WIDTH];

`ifdef MULT_SATURATE_EN
    assign acc_d = (sel_mux && (ovf_q || cout)) ? '1 : sum;
`else
    assign acc_d = sum;
`endif

    // Sticky overflow: cleared in CLEAR (sel_mux=0), accumulates carries in ADD
    assign ovf_d = sel_mux & (ovf_q | cout);

    // Accumulator and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (enable) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus random operands
// compared against an arithmetic product/overflow model and the N+2 latency rule.
module tb_mult_seq_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  mcand;
    logic [CW-1:0] mplier;
    logic          busy, done, overflow, sel_mux, enable;
    logic [W-1:0]  resultado;

    int total = 0;
    int bad   = 0;

    mult_seq_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .multiplicando (mcand),
        .multiplicador (mplier),
        .busy          (busy),
        .done          (done),
        .resultado     (resultado),
        .overflow      (overflow),
        .sel_mux       (sel_mux),
        .enable        (enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_res(input int a, input int b);
        int p;
        p = a * b;
`ifdef MULT_SATURATE_EN
        if (p > int'(MAXV)) return int'(MAXV);
`endif
        return p % int'(MAXV + 1);
    endfunction

    function automatic int exp_ovf(input int a, input int b);
        return (a * b > int'(MAXV)) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; optionally raises start with other operands at cycle poke_c
    task automatic run_op(input int a, input int b, input int poke_c);
        int n_busy = 0;
        int n_sel  = 0;
        int n_done = 0;
        int done_at = 0;
        start  = 1'b1;
        mcand  = W'(a);
        mplier = CW'(b);
        tick();
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = CW'($urandom);
        for (int c = 1; c <= b + 4; c++) begin
            if (busy) n_busy++;
            if (sel_mux) n_sel++;
            if (c == 1) begin
                chk("clear_sel", sel_mux, 0);
                chk("clear_en", enable, 1);
            end
            if (done) begin
                n_done++;
                done_at = c;
                chk("res", resultado, exp_res(a, b));
                chk("ovf", overflow, exp_ovf(a, b));
                chk("done_en", enable, 0);
            end
            if (c == poke_c) begin
                start  = 1'b1;
                mcand  = W'(2);
                mplier = CW'(2);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("busy_cycles", n_busy, b + 1);
        chk("sel_cycles", n_sel, b);
        chk("done_count", n_done, 1);
        chk("done_at", done_at, b + 2);
        chk("held_res", resultado, exp_res(a, b));
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int d1, d2, nd;
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", resultado, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sel", sel_mux, 0);
        chk("rst_en", enable, 0);
        @(negedge clk) rst = 1'b0;

        run_op(3, 5, 0);
        run_op(6, 3, 0);
        run_op(7, 0, 0);
        run_op(3, 5, 3);
        run_op(15, 15, 0);

        // Reset during the second ADD cycle of 4*3
        start  = 1'b1;
        mcand  = W'(4);
        mplier = CW'(3);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_res", resultado, 4);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_res", resultado, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_sel", sel_mux, 0);
        chk("arst_en", enable, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_nodone", done, 0);
        end
        @(negedge clk) rst = 1'b0;
        run_op(1, 1, 0);

        // start held high: 2*2 then 1*3
        d1 = 0;
        d2 = 0;
        nd = 0;
        start  = 1'b1;
        mcand  = W'(2);
        mplier = CW'(2);
        tick();
        for (int c = 1; c <= 14; c++) begin
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = c;
                    chk("cont_res1", resultado, 4);
                    mcand  = W'(1);
                    mplier = CW'(3);
                end else begin
                    d2 = c;
                    chk("cont_res2", resultado, 3);
                end
            end
            if (c == 6) start = 1'b0;
            tick();
        end
        chk("cont_ndone", nd, 2);
        chk("cont_d1", d1, 4);
        chk("cont_d2", d2, 10);

        for (int i = 0; i < 16; i++) begin
            run_op(int'($urandom_range(0, MAXV)), int'($urandom_range(0, (1 << CW) - 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer that computes an unsigned product by repeated addition.
- Built on the team's adder/mux/register accumulate datapath, instantiated internally: accumulator register, adder with feedback, and a 2:1 mux selecting zero (clear) or the multiplicand.
- Start/done handshake for a host block.
- Exports the datapath control strobes (sel_mux, enable) so waveforms can be checked against the shared datapath.

Parameters:
- WIDTH, 4, width of multiplicand, accumulator and result.
- CNT_WIDTH, 4, width of the multiplier (iteration count).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- multiplicando  input  WIDTH  addend; captured when start is accepted.
- multiplicador  input  CNT_WIDTH  number of additions; captured when start is accepted.
- busy  output  1  high in CLEAR and ADD.
- done  output  1  one-cycle pulse in DONE.
- resultado  output  WIDTH  accumulator value, registered.
- overflow  output  1  sticky carry-out flag for the current operation.
- sel_mux  output  1  datapath mux select: 0 = zero, 1 = multiplicand.
- enable  output  1  accumulator load enable.

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; accumulator, counter, captured operands, busy, done, overflow, sel_mux, enable and resultado all 0. Reset mid-operation aborts immediately with no done pulse. After release the block is in IDLE.
- States:
  - IDLE: start=1 at an edge captures both operands -> CLEAR.
  - CLEAR: sel_mux=0, enable=1; accumulator <= 0, overflow <= 0, counter <= captured multiplicador. Next state: DONE if multiplicador==0, else ADD.
  - ADD: sel_mux=1, enable=1; accumulator <= accumulator + multiplicando (WIDTH-bit, modulo 2^WIDTH); overflow <= overflow | carry-out; counter decrements. When counter==1 at the edge (last add) -> DONE, else stay in ADD.
  - DONE: done=1, busy=0, enable=0 -> IDLE unconditionally.
- sel_mux and enable are combinational decodes of the state. busy and done are registered-state decodes, glitch-free.
- Latency, with start sampled at edge k:
  - CLEAR occupies cycle k+1.
  - ADD occupies cycles k+2 .. k+1+N.
  - done is high during cycle k+2+N (k+2 when N=0).
  - Total N+2 cycles from start edge to done.
- resultado mirrors the accumulator. The value in DONE is the final product and is held through IDLE until the next CLEAR.
- start while not in IDLE, including during DONE, is ignored and not queued.
- Operand inputs change while busy: no effect, since they are captured at acceptance.
- A start high continuously restarts a new operation on the first IDLE cycle after DONE.
- N = 2^CNT_WIDTH-1 is legal; the counter never wraps.

Optional Feature:
- Macro: MULT_SATURATE_EN.
- Defined: once a carry-out occurs, the accumulator is forced to all ones and stays saturated for the remaining additions. overflow still sets.
- Undefined: modulo-2^WIDTH wrap. overflow is the only indication.

Test Plan:
- Reset, then multiplicando=3, multiplicador=5, start 1 cycle -> busy for 6 cycles, done pulse at k+7, resultado=15, overflow=0, sel_mux=1 for exactly 5 cycles.
- multiplicando=6, multiplicador=3 -> resultado=2, overflow=1 without macro; resultado=15, overflow=1 with MULT_SATURATE_EN.
- multiplicando=7, multiplicador=0 -> no ADD cycles, done at k+2, resultado=0, overflow=0.
- Start 3*5, then assert start again with 2*2 during ADD -> second request ignored, resultado=15, single done pulse.
- Start 4*3, assert rst during second ADD cycle -> all outputs 0 asynchronously, no done pulse. After release, a 1*1 operation gives resultado=1.
- start held high for 2*2 then 1*3 (change operands after first done) -> two done pulses separated by one IDLE cycle, resultado=4 then 3.
